hsp_drain_packer: RTL and testbench
===================================

Name: hsp_drain_packer

Overview:
- Sits directly downstream of the HSP FIFO and drains one HSP entry (subject pos, query pos, length, score) at a time.
- Drops entries below a programmable score threshold or with zero length.
- Packs each surviving entry into one 32-bit word on a valid/ready stream towards the PCIe host-transfer logic.
- On a batch-done pulse, drains the FIFO completely, then appends a trailer word carrying the kept-entry count and marked end-of-packet.

Parameters:
- DATA_W, 8: width of each HSP field; the stream word is 4*DATA_W bits wide.
- CNT_W, 16: width of the kept/dropped counters; must be <= 2*DATA_W.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- fifo_empty  in  1  empty flag from the HSP FIFO.
- fifo_rd_en  out  1  pop request to the HSP FIFO.
- fifo_s, fifo_q, fifo_l, fifo_score  in  DATA_W each  FIFO read data; valid exactly one cycle after a cycle with fifo_rd_en=1 and fifo_empty=0.
- score_thresh  in  DATA_W  minimum score kept (unsigned).
- batch_done  in  1  single-cycle pulse: upstream has finished the current batch.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accepts the word when out_valid=1 and out_ready=1.
- out_data  out  4*DATA_W  packed word.
- out_eop  out  1  high with the trailer word only.
- kept_cnt  out  CNT_W  entries forwarded in the current batch.
- drop_cnt  out  CNT_W  entries dropped in the current batch.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; fifo_rd_en=0, out_valid=0, out_data=0, out_eop=0, kept_cnt=0, drop_cnt=0, batch-pending flag=0. Reset mid-transfer abandons any held word; nothing is replayed.
- FSM states:
  - IDLE: if fifo_empty=0, go to POP. Else if pending=1, go to TRAILER. Else stay. A non-empty FIFO takes priority over the trailer.
  - POP: fifo_rd_en=1 for exactly this one cycle; go to CAPTURE. fifo_rd_en is 0 in every other state.
  - CAPTURE: sample fifo_* and score_thresh.
    - Keep if fifo_l != 0 and fifo_score >= score_thresh: out_data = {s, q, l, score} with s in the MSBs; out_valid=1; kept_cnt+1; go to HOLD.
    - Otherwise: drop_cnt+1; go to IDLE.
  - HOLD: out_data and out_valid are held stable until out_ready=1, then out_valid=0 and go to IDLE.
  - TRAILER: out_data = {2*DATA_W ones, kept_cnt zero-extended to 2*DATA_W}; out_valid=1, out_eop=1; hold until out_ready=1. On acceptance: out_valid=0, out_eop=0, kept_cnt=0, drop_cnt=0, pending=0, go to IDLE.
- batch_done sets pending in any state. Pulses while pending=1 are merged. A pulse in the same cycle the trailer is accepted sets pending again, so a second trailer follows.
- Entries written to the FIFO after batch_done but before the trailer belong to the current batch.
- Counters saturate at all-ones and never wrap.
- Throughput: 3 cycles per kept entry with out_ready=1; 2 cycles per dropped entry.
- Latency: a kept word is valid 2 cycles after leaving IDLE.
- out_ready is ignored while out_valid=0.
- The FIFO is never popped while a word is held (single-entry output buffer).

Test Plan:
- Reset: drive rst=0 mid-HOLD with out_valid=1 -> all outputs 0 immediately; after rst=1 the FSM is IDLE and the held word is lost.
- Filter: score_thresh=8'h10; FIFO entries (s,q,l,score) = (01,02,05,10), (03,04,05,0F), (05,06,00,40) -> one word 0x0102_0510; kept_cnt=1, drop_cnt=2.
- Backpressure: out_ready=0 for 5 cycles on word 0xAABB_0C20 -> out_data stable, fifo_rd_en stays 0 throughout; accepted on the first cycle out_ready=1.
- Batch end: 3 kept entries, then batch_done while the FIFO still holds 2 kept entries -> 5 data words, then trailer 0xFFFF_0005 with out_eop=1; counters read 0 afterwards.
- Empty batch: batch_done with FIFO empty -> trailer 0xFFFF_0000 two cycles later; a second batch_done while the trailer is held -> a second trailer 0xFFFF_0000.
- Saturation: with CNT_W=4, forward 20 kept entries -> kept_cnt stops at 4'hF; trailer = 0xFFFF_000F.

Source files
------------

// File: rtl/hsp_drain_packer_if.sv
// Output stream from the HSP drain packer towards the PCIe host-transfer logic.
// The master drives the word, its valid flag and the end-of-packet mark.
interface hsp_drain_packer_if #(
  parameter int DATA_W = 8
);
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DATA_W-1:0]   out_data;
  logic                  out_eop;

  modport master (output out_valid, output out_data, output out_eop, input out_ready);
  modport slave  (input out_valid, input out_data, input out_eop, output out_ready);
endinterface

// File: rtl/hsp_drain_packer.sv
// Drains HSP FIFO entries one at a time, filters them by score and length, and packs
// survivors into stream words; a batch-done pulse ends the batch with a count trailer.
module hsp_drain_packer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_s,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic [DATA_W-1:0] fifo_l,
  input  logic [DATA_W-1:0] fifo_score,
  input  logic [DATA_W-1:0] score_thresh,
  input  logic              batch_done,
  hsp_drain_packer_if.master stream,
  output logic [CNT_W-1:0]  kept_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int HALF_W = 2 * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_CAPTURE,
    S_HOLD,
    S_TRAILER
  } state_t;

  state_t              r_state;
  logic                r_fifo_rd_en;
  logic                r_out_valid;
  logic                r_out_eop;
  logic [4*DATA_W-1:0] r_out_data;
  logic [CNT_W-1:0]    r_kept_cnt;
  logic [CNT_W-1:0]    r_drop_cnt;
  logic                r_pending;

  logic                w_keep;
  logic                w_dispatch;

  assign w_keep = (fifo_l != '0) && (fifo_score >= score_thresh);

  // Any cycle that would land in IDLE makes the IDLE decision immediately instead,
  // which keeps kept entries at 3 cycles and dropped entries at 2 cycles apiece.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path infers a latch.
    w_dispatch = 1'b0;
    case (r_state)
      S_IDLE:    w_dispatch = 1'b1;
      S_CAPTURE: w_dispatch = !w_keep;
      S_HOLD:    w_dispatch = stream.out_ready;
      default:   w_dispatch = 1'b0;
    endcase
  end

  // NOTE: state is written with <= only; where two statements below assign the same
  // register in one cycle, the later one (the dispatch decision) is the one that lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_fifo_rd_en <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_eop    <= 1'b0;
      r_out_data   <= '0;
      r_kept_cnt   <= '0;
      r_drop_cnt   <= '0;
      r_pending    <= 1'b0;
    end else begin
      r_fifo_rd_en <= 1'b0;
      if (batch_done) r_pending <= 1'b1;

      case (r_state)
        S_POP: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          if (w_keep) begin
            r_out_data  <= {fifo_s, fifo_q, fifo_l, fifo_score};
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
            if (r_kept_cnt != '1) r_kept_cnt <= r_kept_cnt + CNT_W'(1);
          end else if (r_drop_cnt != '1) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
          end
        end
        S_HOLD: if (stream.out_ready) r_out_valid <= 1'b0;
        S_TRAILER: begin
          if (stream.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_eop   <= 1'b0;
            r_kept_cnt  <= '0;
            r_drop_cnt  <= '0;
            // A pulse coinciding with acceptance opens the next batch's trailer.
            r_pending   <= batch_done;
            r_state     <= S_IDLE;
          end
        end
        default: ;
      endcase

      if (w_dispatch) begin
        if (!fifo_empty) begin
          r_state      <= S_POP;
          r_fifo_rd_en <= 1'b1;
        end else if (r_pending) begin
          r_state     <= S_TRAILER;
          r_out_data  <= {{HALF_W{1'b1}}, HALF_W'(r_kept_cnt)};
          r_out_valid <= 1'b1;
          r_out_eop   <= 1'b1;
        end else begin
          r_state <= S_IDLE;
        end
      end
    end
  end

  assign fifo_rd_en       = r_fifo_rd_en;
  assign stream.out_valid = r_out_valid;
  assign stream.out_data  = r_out_data;
  assign stream.out_eop   = r_out_eop;
  assign kept_cnt         = r_kept_cnt;
  assign drop_cnt         = r_drop_cnt;

endmodule

// File: tb/tb_hsp_drain_packer.sv
// Directed bench for hsp_drain_packer: one 16-bit-counter instance for filtering,
// backpressure, batch and reset scenarios, and one 4-bit-counter instance for saturation.
module tb_hsp_drain_packer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: CNT_W = 16
  logic        fifo_empty0, rd_en0, bd0;
  logic [7:0]  s0d = '0, q0d = '0, l0d = '0, sc0d = '0, thresh0;
  logic [15:0] kept0, drop0;
  logic [31:0] mem0 [0:63];
  int          wr0 = 0, rd0 = 0;
  hsp_drain_packer_if #(.DATA_W(8)) st0 ();

  // Instance 1: CNT_W = 4
  logic        fifo_empty1, rd_en1, bd1;
  logic [7:0]  s1d = '0, q1d = '0, l1d = '0, sc1d = '0, thresh1;
  logic [3:0]  kept1, drop1;
  logic [31:0] mem1 [0:63];
  int          wr1 = 0, rd1 = 0;
  hsp_drain_packer_if #(.DATA_W(8)) st1 ();

  hsp_drain_packer #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty0), .fifo_rd_en(rd_en0),
    .fifo_s(s0d), .fifo_q(q0d), .fifo_l(l0d), .fifo_score(sc0d),
    .score_thresh(thresh0), .batch_done(bd0), .stream(st0),
    .kept_cnt(kept0), .drop_cnt(drop0)
  );

  hsp_drain_packer #(.DATA_W(8), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty1), .fifo_rd_en(rd_en1),
    .fifo_s(s1d), .fifo_q(q1d), .fifo_l(l1d), .fifo_score(sc1d),
    .score_thresh(thresh1), .batch_done(bd1), .stream(st1),
    .kept_cnt(kept1), .drop_cnt(drop1)
  );

  // FIFO models: read data appears the cycle after a pop of a non-empty FIFO.
  assign fifo_empty0 = (wr0 == rd0);
  assign fifo_empty1 = (wr1 == rd1);

  always @(posedge clk) begin
    if (rd_en0 && (wr0 != rd0)) begin
      {s0d, q0d, l0d, sc0d} <= mem0[rd0];
      rd0 <= rd0 + 1;
    end
  end

  always @(posedge clk) begin
    if (rd_en1 && (wr1 != rd1)) begin
      {s1d, q1d, l1d, sc1d} <= mem1[rd1];
      rd1 <= rd1 + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic push0(input logic [31:0] e);
    mem0[wr0] = e;
    wr0++;
  endtask

  task automatic push1(input logic [31:0] e);
    mem1[wr1] = e;
    wr1++;
  endtask

  task automatic wait_valid0(input string tag);
    int i;
    i = 0;
    while (!st0.out_valid && i < 50) begin
      tick();
      i++;
    end
    chk({tag, " valid"}, 32'(st0.out_valid), 32'd1);
  endtask

  logic [31:0] got_data [0:7];
  logic        got_eop  [0:7];
  int          words;
  int          n_acc;

  initial begin
    thresh0 = 8'h10;
    thresh1 = 8'h00;
    bd0 = 1'b0;
    bd1 = 1'b0;
    st0.out_ready = 1'b0;
    st1.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst valid", 32'(st0.out_valid), 32'd0);
    chk("rst data",  st0.out_data,       32'd0);
    chk("rst eop",   32'(st0.out_eop),   32'd0);
    chk("rst rd_en", 32'(rd_en0),        32'd0);
    chk("rst kept",  32'(kept0),         32'd0);
    chk("rst drop",  32'(drop0),         32'd0);
    tick();
    rst = 1'b1;
    tick();
    tick();

    // Filter: one keeper, one low score, one zero length; latency 2 cycles after IDLE
    push0(32'h0102_0510);
    push0(32'h0304_050F);
    push0(32'h0506_0040);
    tick();
    chk("filt pop", 32'(rd_en0), 32'd1);
    tick();
    chk("filt early", 32'(st0.out_valid), 32'd0);
    tick();
    chk("filt valid", 32'(st0.out_valid), 32'd1);
    chk("filt data",  st0.out_data,       32'h0102_0510);
    chk("filt eop",   32'(st0.out_eop),   32'd0);
    st0.out_ready = 1'b1;
    tick();
    st0.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("filt kept",  32'(kept0), 32'd1);
    chk("filt drop",  32'(drop0), 32'd2);
    chk("filt idle",  32'(st0.out_valid), 32'd0);

    // Backpressure: word held 5 cycles with a second entry waiting behind it
    push0(32'hAABB_0C20);
    wait_valid0("bp");
    push0(32'h1122_0130);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp data %0d", i),  st0.out_data,       32'hAABB_0C20);
      chk($sformatf("bp valid %0d", i), 32'(st0.out_valid), 32'd1);
      chk($sformatf("bp rd_en %0d", i), 32'(rd_en0),        32'd0);
    end
    st0.out_ready = 1'b1;
    tick();
    st0.out_ready = 1'b0;
    chk("bp accepted", 32'(st0.out_valid), 32'd0);
    wait_valid0("bp2");
    chk("bp2 data", st0.out_data, 32'h1122_0130);
    st0.out_ready = 1'b1;
    tick();
    st0.out_ready = 1'b0;
    tick();
    tick();
    chk("bp kept", 32'(kept0), 32'd3);

    // Close this batch: trailer carries the 3 kept entries
    bd0 = 1'b1;
    tick();
    bd0 = 1'b0;
    wait_valid0("trl3");
    chk("trl3 data", st0.out_data,     32'hFFFF_0003);
    chk("trl3 eop",  32'(st0.out_eop), 32'd1);
    st0.out_ready = 1'b1;
    tick();
    st0.out_ready = 1'b0;
    chk("trl3 kept clr", 32'(kept0), 32'd0);
    chk("trl3 drop clr", 32'(drop0), 32'd0);

    // Batch end: done pulses (merged) while entries remain queued
    push0(32'h1020_0110);
    push0(32'h3040_0220);
    push0(32'h5060_0330);
    push0(32'h7080_0440);
    push0(32'h90A0_0550);
    bd0 = 1'b1;
    tick();
    bd0 = 1'b0;
    tick();
    bd0 = 1'b1;
    tick();
    bd0 = 1'b0;
    st0.out_ready = 1'b1;
    words = 0;
    for (int c = 0; c < 300 && words < 6; c++) begin
      if (st0.out_valid) begin
        got_data[words] = st0.out_data;
        got_eop[words]  = st0.out_eop;
        words++;
      end
      tick();
    end
    st0.out_ready = 1'b0;
    chk("batch words", 32'(words), 32'd6);
    chk("batch w0", got_data[0], 32'h1020_0110);
    chk("batch w1", got_data[1], 32'h3040_0220);
    chk("batch w2", got_data[2], 32'h5060_0330);
    chk("batch w3", got_data[3], 32'h7080_0440);
    chk("batch w4", got_data[4], 32'h90A0_0550);
    chk("batch w4 eop", 32'(got_eop[4]), 32'd0);
    chk("batch trl",     got_data[5],       32'hFFFF_0005);
    chk("batch trl eop", 32'(got_eop[5]),   32'd1);
    for (int i = 0; i < 8; i++) tick();
    chk("batch no 2nd trl", 32'(st0.out_valid), 32'd0);
    chk("batch kept clr",   32'(kept0),         32'd0);
    chk("batch drop clr",   32'(drop0),         32'd0);

    // Empty batch: trailer two cycles after the pulse; a pulse on acceptance re-arms it
    bd0 = 1'b1;
    tick();
    bd0 = 1'b0;
    chk("empty early", 32'(st0.out_valid), 32'd0);
    tick();
    chk("empty valid", 32'(st0.out_valid), 32'd1);
    chk("empty data",  st0.out_data,       32'hFFFF_0000);
    chk("empty eop",   32'(st0.out_eop),   32'd1);
    tick();
    tick();
    st0.out_ready = 1'b1;
    bd0 = 1'b1;
    tick();
    st0.out_ready = 1'b0;
    bd0 = 1'b0;
    chk("empty acc", 32'(st0.out_valid), 32'd0);
    tick();
    chk("empty2 valid", 32'(st0.out_valid), 32'd1);
    chk("empty2 data",  st0.out_data,       32'hFFFF_0000);
    chk("empty2 eop",   32'(st0.out_eop),   32'd1);
    st0.out_ready = 1'b1;
    tick();
    st0.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("empty no 3rd", 32'(st0.out_valid), 32'd0);

    // Reset mid-HOLD: outputs clear at once and the held word is lost
    push0(32'h0A0B_0C40);
    wait_valid0("rsthold");
    chk("rsthold data", st0.out_data, 32'h0A0B_0C40);
    rst = 1'b0;
    #1;
    chk("rsthold valid0", 32'(st0.out_valid), 32'd0);
    chk("rsthold data0",  st0.out_data,       32'd0);
    chk("rsthold kept0",  32'(kept0),         32'd0);
    tick();
    rst = 1'b1;
    st0.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("rsthold lost",  32'(st0.out_valid), 32'd0);
    chk("rsthold rd_en", 32'(rd_en0),        32'd0);
    st0.out_ready = 1'b0;

    // Saturation on the 4-bit instance: 20 kept entries
    for (int i = 0; i < 20; i++) push1({8'(i + 1), 8'h00, 8'h01, 8'h80});
    n_acc = 0;
    for (int c = 0; c < 300 && n_acc < 20; c++) begin
      if (st1.out_valid) n_acc++;
      tick();
    end
    chk("sat words", 32'(n_acc), 32'd20);
    chk("sat kept",  32'(kept1), 32'hF);
    chk("sat drop",  32'(drop1), 32'h0);
    st1.out_ready = 1'b0;
    bd1 = 1'b1;
    tick();
    bd1 = 1'b0;
    tick();
    chk("sat trl valid", 32'(st1.out_valid), 32'd1);
    chk("sat trl data",  st1.out_data,       32'hFFFF_000F);
    chk("sat trl eop",   32'(st1.out_eop),   32'd1);
    st1.out_ready = 1'b1;
    tick();
    chk("sat kept clr", 32'(kept1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
